// File: rtl/mem_wait_pkg.sv
// Shared definitions for the memory wait-state controller.
//   - ctrl_state_e : controller FSM states (IDLE, ACCESS, DONE)
//   - WAIT_CYCLES_DEFAULT : default number of memory wait states
//   - CNT_W : width of the wait-state counter
//   - is_aligned() : word-alignment test on the two address LSBs
package mem_wait_pkg;

    localparam int unsigned WAIT_CYCLES_DEFAULT = 32'd2;
    localparam int unsigned CNT_W               = 32'd4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } ctrl_state_e;

    // A word access is legal only when the byte offset is zero.
    function automatic logic is_aligned(input logic [1:0] adr_lsb);
        return (adr_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/wait_counter.sv
// Wait-state counter for the memory controller.
// Ports:
//   clk, rst  : clock, asynchronous active-low reset
//   load      : clear the count to zero (start of an access)
//   enable    : advance the count by one
//   tc        : terminal count reached (count == TERMINAL)
// The count saturates at its maximum so it can never wrap inside one access.
module wait_counter
    import mem_wait_pkg::*;
#(
    parameter int unsigned TERMINAL = WAIT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic tc
);

    localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(TERMINAL);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next-count selection: load wins over enable, saturate at the top.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = '0;
        end else if (enable && (count_q != CNT_MAX)) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == TC_VAL);

endmodule

// File: rtl/mem_wait_ctrl.sv
// Memory wait-state controller between the processor and data_mem.
// Accepts one word access at a time, holds the memory strobe for
// WAIT_CYCLES+1 cycles, then pulses cpu_ready for one cycle (DONE state).
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   cpu_adr, cpu_wdata       : processor address / store data
//   cpu_read, cpu_write      : processor request strobes, held until cpu_ready
//   cpu_rdata                : load data, held until the next completed read
//   cpu_ready                : one-cycle completion pulse
//   err                      : sticky error (misaligned or read+write together)
//   mem_adr, mem_wdata       : data_mem address / write data
//   mem_read, mem_write      : data_mem strobes, only ever high in ACCESS
//   mem_rdata                : data_mem read data (combinational from mem_adr)
module mem_wait_ctrl
    import mem_wait_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT, // legal 0..15
    parameter int unsigned AW          = 32'd32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] cpu_adr,
    input  logic [AW-1:0] cpu_wdata,
    input  logic          cpu_read,
    input  logic          cpu_write,
    output logic [AW-1:0] cpu_rdata,
    output logic          cpu_ready,
    output logic          err,
    output logic [AW-1:0] mem_adr,
    output logic [AW-1:0] mem_wdata,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [AW-1:0] mem_rdata
);

    ctrl_state_e   state_q,     state_d;
    logic [AW-1:0] adr_q,       adr_d;
    logic [AW-1:0] wdata_q,     wdata_d;
    logic [AW-1:0] rdata_q,     rdata_d;
    logic          ready_q,     ready_d;
    logic          err_q,       err_d;
    logic          mem_read_q,  mem_read_d;
    logic          mem_write_q, mem_write_d;

    logic cnt_load_s;
    logic cnt_en_s;
    logic cnt_tc_s;

    wait_counter #(
        .TERMINAL (WAIT_CYCLES)
    ) u_wait_counter (
        .clk    (clk),
        .rst    (rst),
        .load   (cnt_load_s),
        .enable (cnt_en_s),
        .tc     (cnt_tc_s)
    );

    // Next-state and next-output logic. The memory strobes themselves
    // remember the operation while in ACCESS, so no separate op flop exists.
    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        ready_d     = 1'b0;
        err_d       = err_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        cnt_load_s  = 1'b0;
        cnt_en_s    = 1'b0;

        case (state_q)
            IDLE: begin
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                if (cpu_read || cpu_write) begin
                    cnt_load_s = 1'b1;
                    if (!is_aligned(cpu_adr[1:0])) begin
                        // Misaligned: no memory cycle, complete with error.
                        err_d   = 1'b1;
                        ready_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        adr_d       = cpu_adr;
                        wdata_d     = cpu_wdata;
                        // Read and write together resolves to a write.
                        mem_write_d = cpu_write;
                        mem_read_d  = cpu_read & ~cpu_write;
                        if (cpu_read && cpu_write) begin
                            err_d = 1'b1;
                        end else begin
                            err_d = err_q;
                        end
                        state_d = ACCESS;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_tc_s) begin
                    // Last wait cycle: data_mem output is valid for a read.
                    if (mem_read_q) begin
                        rdata_d = mem_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    ready_d     = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_en_s = 1'b1;
                    state_d  = ACCESS;
                end
            end
            DONE: begin
                // Strobes still held by the processor here are ignored.
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // FSM state and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            adr_q       <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    assign cpu_rdata = rdata_q;
    assign cpu_ready = ready_q;
    assign err       = err_q;
    assign mem_adr   = adr_q;
    assign mem_wdata = wdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;

endmodule

// File: tb/tb_mem_wait_ctrl.sv
// Directed testbench for mem_wait_ctrl.
// dut0 runs with WAIT_CYCLES=2, dut1 with WAIT_CYCLES=0; each has a small
// word memory model (64 words, indexed by address bits [7:2]).
// Latency is counted in rising edges after the request edge, at the edge
// where the processor samples cpu_ready high.
module tb_mem_wait_ctrl;

    logic clk;
    logic rst;

    logic [31:0] adr0, wdata0, rdata0, madr0, mwdata0, mrdata0;
    logic        rd0, wr0, ready0, err0, mrd0, mwr0;
    logic [31:0] adr1, wdata1, rdata1, madr1, mwdata1, mrdata1;
    logic        rd1, wr1, ready1, err1, mrd1, mwr1;

    logic [31:0] mem0 [0:63];
    logic [31:0] mem1 [0:63];

    int checks;
    int failures;

    mem_wait_ctrl #(.WAIT_CYCLES(2), .AW(32)) dut0 (
        .clk(clk), .rst(rst),
        .cpu_adr(adr0), .cpu_wdata(wdata0), .cpu_read(rd0), .cpu_write(wr0),
        .cpu_rdata(rdata0), .cpu_ready(ready0), .err(err0),
        .mem_adr(madr0), .mem_wdata(mwdata0), .mem_read(mrd0), .mem_write(mwr0),
        .mem_rdata(mrdata0)
    );

    mem_wait_ctrl #(.WAIT_CYCLES(0), .AW(32)) dut1 (
        .clk(clk), .rst(rst),
        .cpu_adr(adr1), .cpu_wdata(wdata1), .cpu_read(rd1), .cpu_write(wr1),
        .cpu_rdata(rdata1), .cpu_ready(ready1), .err(err1),
        .mem_adr(madr1), .mem_wdata(mwdata1), .mem_read(mrd1), .mem_write(mwr1),
        .mem_rdata(mrdata1)
    );

    always #5 clk = ~clk;

    assign mrdata0 = mem0[madr0[7:2]];
    assign mrdata1 = mem1[madr1[7:2]];

    // Memory models: cleared/preloaded while in reset, written on mem_write.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) begin
                mem0[i] <= 32'h0;
                mem1[i] <= 32'h0;
            end
            mem1[0] <= 32'h1111_1111;
            mem1[1] <= 32'h2222_2222;
        end else begin
            if (mwr0) mem0[madr0[7:2]] <= mwdata0;
            if (mwr1) mem1[madr1[7:2]] <= mwdata1;
        end
    end

    // One processor access on dut0 (sel=0) or dut1 (sel=1): strobes held until
    // ready is seen; reports latency (0 = no ready in budget) and strobe counts.
    task automatic access(input bit sel, input logic [31:0] a, input logic [31:0] d,
                          input logic r, input logic w,
                          output int lat, output int nrd, output int nwr, output int nboth);
        logic srd, swr, srdy;
        @(negedge clk);
        if (sel) begin adr1 = a; wdata1 = d; rd1 = r; wr1 = w; end
        else     begin adr0 = a; wdata0 = d; rd0 = r; wr0 = w; end
        lat = 0; nrd = 0; nwr = 0; nboth = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            srd  = sel ? mrd1 : mrd0;
            swr  = sel ? mwr1 : mwr0;
            srdy = sel ? ready1 : ready0;
            if (srd) nrd++;
            if (swr) nwr++;
            if (srd && swr) nboth++;
            if (srdy) begin
                lat = k;
                break;
            end
        end
        if (sel) begin rd1 = 1'b0; wr1 = 1'b0; end
        else     begin rd0 = 1'b0; wr0 = 1'b0; end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({mrd0, mwr0, ready0, err0} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 0000", {mrd0, mwr0, ready0, err0});
        end
        checks++;
        if ({rdata0, madr0, mwdata0} !== 96'h0) begin
            failures++;
            $display("FAIL reset_data: got rdata=%h adr=%h wdata=%h expected 0", rdata0, madr0, mwdata0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({mrd0, mwr0, ready0, err0, mrd1, mwr1, ready1} !== 7'b0) begin
            failures++;
            $display("FAIL idle_after_reset: got %b expected 0", {mrd0, mwr0, ready0, err0, mrd1, mwr1, ready1});
        end
    endtask

    task automatic test_write();
        int lat, nrd, nwr, nb;
        access(1'b0, 32'h40, 32'hDEAD_BEEF, 1'b0, 1'b1, lat, nrd, nwr, nb);
        checks++;
        if (lat !== 4) begin failures++; $display("FAIL s1_latency: got %0d expected 4", lat); end
        checks++;
        if (nwr !== 3 || nrd !== 0) begin
            failures++; $display("FAIL s1_strobes: got wr=%0d rd=%0d expected wr=3 rd=0", nwr, nrd);
        end
        @(negedge clk);
        checks++;
        if (ready0 !== 1'b0) begin failures++; $display("FAIL s1_ready_pulse: got %b expected 0", ready0); end
        checks++;
        if (mem0[16] !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL s1_mem: got %h expected deadbeef", mem0[16]);
        end
    endtask

    task automatic test_read_hold();
        int lat, nrd, nwr, nb;
        access(1'b0, 32'h40, 32'h0, 1'b1, 1'b0, lat, nrd, nwr, nb);
        checks++;
        if (lat !== 4 || nrd !== 3 || nwr !== 0) begin
            failures++; $display("FAIL s2_read_timing: got lat=%0d rd=%0d wr=%0d expected 4 3 0", lat, nrd, nwr);
        end
        checks++;
        if (rdata0 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL s2_rdata: got %h expected deadbeef", rdata0); end
        access(1'b0, 32'h44, 32'h1234_5678, 1'b0, 1'b1, lat, nrd, nwr, nb);
        checks++;
        if (rdata0 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL s2_rdata_hold: got %h expected deadbeef", rdata0); end
        checks++;
        if (mem0[17] !== 32'h1234_5678 || err0 !== 1'b0) begin
            failures++; $display("FAIL s2_write44: got mem=%h err=%b expected 12345678 0", mem0[17], err0);
        end
    endtask

    task automatic test_misaligned();
        int lat, nrd, nwr, nb;
        access(1'b0, 32'h42, 32'h0, 1'b1, 1'b0, lat, nrd, nwr, nb);
        checks++;
        if (lat == 0) begin failures++; $display("FAIL s4_ready: got no ready expected pulse"); end
        checks++;
        if (nrd !== 0 || nwr !== 0) begin
            failures++; $display("FAIL s4_no_strobe: got rd=%0d wr=%0d expected 0 0", nrd, nwr);
        end
        checks++;
        if (err0 !== 1'b1) begin failures++; $display("FAIL s4_err: got %b expected 1", err0); end
        checks++;
        if (rdata0 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL s4_rdata: got %h expected deadbeef", rdata0); end
    endtask

    task automatic test_both();
        int lat, nrd, nwr, nb;
        access(1'b0, 32'h80, 32'hCAFE_F00D, 1'b1, 1'b1, lat, nrd, nwr, nb);
        checks++;
        if (nwr !== 3 || nrd !== 0 || nb !== 0) begin
            failures++; $display("FAIL s3_strobes: got wr=%0d rd=%0d both=%0d expected 3 0 0", nwr, nrd, nb);
        end
        checks++;
        if (mem0[32] !== 32'hCAFE_F00D || err0 !== 1'b1) begin
            failures++; $display("FAIL s3_write_err: got mem=%h err=%b expected cafef00d 1", mem0[32], err0);
        end
        access(1'b0, 32'h80, 32'h0, 1'b1, 1'b0, lat, nrd, nwr, nb);
        checks++;
        if (rdata0 !== 32'hCAFE_F00D || err0 !== 1'b1) begin
            failures++; $display("FAIL s3_sticky: got rdata=%h err=%b expected cafef00d 1", rdata0, err0);
        end
    endtask

    task automatic test_reset_mid_access();
        int lat, nrd, nwr, nb, seen;
        @(negedge clk);
        adr0 = 32'h40; rd0 = 1'b1;
        @(posedge clk);   // request edge: first ACCESS cycle begins
        @(posedge clk);   // second ACCESS cycle begins
        #2;
        checks++;
        if (mrd0 !== 1'b1) begin failures++; $display("FAIL s5_in_access: got mem_read=%b expected 1", mrd0); end
        rst = 1'b0;
        #1;
        checks++;
        if (mrd0 !== 1'b0 || mwr0 !== 1'b0 || err0 !== 1'b0) begin
            failures++; $display("FAIL s5_async_drop: got rd=%b wr=%b err=%b expected 0 0 0", mrd0, mwr0, err0);
        end
        rd0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (ready0 || mrd0 || mwr0) seen++;
        end
        checks++;
        if (seen !== 0) begin failures++; $display("FAIL s5_abandoned: got %0d active cycles expected 0", seen); end
        access(1'b0, 32'h4, 32'h5555_AAAA, 1'b0, 1'b1, lat, nrd, nwr, nb);
        checks++;
        if (lat !== 4 || nwr !== 3) begin
            failures++; $display("FAIL s5_idle_after: got lat=%0d wr=%0d expected 4 3", lat, nwr);
        end
    endtask

    task automatic test_back_to_back();
        int lat, nrd, nwr, nb;
        access(1'b1, 32'h0, 32'h0, 1'b1, 1'b0, lat, nrd, nwr, nb);
        checks++;
        if (lat !== 2 || nrd !== 1 || rdata1 !== 32'h1111_1111) begin
            failures++; $display("FAIL s6_read0: got lat=%0d rd=%0d data=%h expected 2 1 11111111", lat, nrd, rdata1);
        end
        access(1'b1, 32'h4, 32'h0, 1'b1, 1'b0, lat, nrd, nwr, nb);
        checks++;
        if (lat !== 2 || nrd !== 1 || rdata1 !== 32'h2222_2222) begin
            failures++; $display("FAIL s6_read4: got lat=%0d rd=%0d data=%h expected 2 1 22222222", lat, nrd, rdata1);
        end
    endtask

    initial begin
        clk = 1'b0;
        checks = 0;
        failures = 0;
        adr0 = 32'h0; wdata0 = 32'h0; rd0 = 1'b0; wr0 = 1'b0;
        adr1 = 32'h0; wdata1 = 32'h0; rd1 = 1'b0; wr1 = 1'b0;
        test_reset();
        test_write();
        test_read_hold();
        test_misaligned();
        test_both();
        test_reset_mid_access();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_wait_ctrl.md
MEM_WAIT_CTRL -- requirements
Module: mem_wait_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, meaning memory wait states per access (legal 0..15).
REQ-002 SHALL have parameter AW, default 32, meaning address and data width.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset, asynchronous, active-low.
REQ-005 SHALL have port cpu_adr, input, AW, meaning byte address from the processor.
REQ-006 SHALL have port cpu_wdata, input, AW, meaning store data from the processor (register B output).
REQ-007 SHALL have ports cpu_read and cpu_write, input, 1 each, meaning access request strobes.
REQ-008 SHALL have port cpu_rdata, output, AW, meaning load data returned to the processor.
REQ-009 SHALL have port cpu_ready, output, 1, meaning access complete; one-cycle pulse.
REQ-010 SHALL have port err, output, 1, meaning sticky error flag.
REQ-011 SHALL have ports mem_adr and mem_wdata, output, AW, and mem_read and mem_write, output, 1, meaning the data_mem-side request.
REQ-012 SHALL have port mem_rdata, input, AW, meaning data_mem read data, combinational from mem_adr.

Function
REQ-013 SHALL implement states IDLE, ACCESS, DONE.
REQ-014 In IDLE, on cpu_read or cpu_write with cpu_adr[1:0]==0, it SHALL latch address, write data, and operation, clear the wait counter, and enter ACCESS.
REQ-015 In ACCESS, it SHALL drive mem_adr and mem_wdata from the latched values and hold mem_read or mem_write high for exactly WAIT_CYCLES+1 cycles.
REQ-016 On the last ACCESS cycle, a read SHALL capture mem_rdata into cpu_rdata; the FSM SHALL then enter DONE.
REQ-017 In DONE, cpu_ready SHALL be 1 for one cycle and the FSM SHALL return to IDLE; request latency SHALL be WAIT_CYCLES+2 cycles from the request edge to the ready pulse.
REQ-018 cpu_rdata SHALL hold its value until the next completed read; writes SHALL not alter it.
REQ-019 If cpu_read and cpu_write are both high in IDLE, it SHALL perform a write and set err.
REQ-020 A misaligned request (cpu_adr[1:0]!=0) SHALL issue no memory strobe, set err, and still pulse cpu_ready through DONE.
REQ-021 Request strobes in ACCESS or DONE SHALL be ignored; the processor holds its strobes until cpu_ready.
REQ-022 When WAIT_CYCLES=0, ACCESS SHALL last exactly one cycle.
REQ-023 The wait counter SHALL be 4 bits wide and SHALL not wrap within one access.
REQ-024 mem_read and mem_write SHALL be 0 outside ACCESS, and SHALL never both be 1.

Reset
REQ-025 When rst=0, regardless of clk, the FSM SHALL enter IDLE, outputs cpu_rdata, mem_adr, and mem_wdata SHALL be 0, cpu_ready, err, mem_read, and mem_write SHALL be 0, and the counter SHALL be 0.
REQ-026 Reset asserted mid-ACCESS SHALL drop memory strobes immediately and abandon the access without a ready pulse.
REQ-027 err SHALL clear only on reset.

Structure
REQ-028 The state enumeration and the default WAIT_CYCLES value SHALL live in shared package mem_wait_pkg.
REQ-029 The wait counter SHALL be a sub-module wait_counter (load, enable, terminal-count output); the rest SHALL be flat.

Verification
REQ-030 Scenario 1 SHALL check: WAIT_CYCLES=2, write 0xDEADBEEF to 0x40 -> mem_write high 3 cycles, cpu_ready pulses 4 cycles after the request edge.
REQ-031 Scenario 2 SHALL check: read 0x40 after scenario 1 -> cpu_rdata=0xDEADBEEF at the ready pulse, held through a following write to 0x44.
REQ-032 Scenario 3 SHALL check: cpu_read and cpu_write both high at 0x80 -> write performed, err=1, and err stays 1 across later clean accesses.
REQ-033 Scenario 4 SHALL check: read at 0x42 -> no mem_read, err=1, cpu_ready pulses, cpu_rdata unchanged.
REQ-034 Scenario 5 SHALL check: rst driven low during the second ACCESS cycle -> mem strobes 0 before the next clk edge, no cpu_ready, IDLE after release.
REQ-035 Scenario 6 SHALL check: WAIT_CYCLES=0, back-to-back reads of 0x0 and 0x4 -> each ready pulse 2 cycles after its request edge, correct data.
